// File: rtl/audio_dac_serializer.sv
// ---------------------------------------------------------------------------
// audio_dac_serializer
//   Serializes 16-bit stereo sample pairs into a DSP mode B stream for a
//   slave-mode audio codec. A one-entry holding buffer decouples the sample
//   producer from the frame timing. If no pair is waiting when a frame
//   starts, that frame is muted.
//
// Parameters
//   BCLK_DIV     i_clk cycles per BCLK half-period (2..255)
//   FRAME_BCLKS  BCLK periods per frame (33..256)
//
// Ports
//   i_clk            global clock
//   i_nrst           asynchronous active-low reset
//   i_init_ready     codec configured; the serializer runs only while high
//   i_sample_valid   i_left/i_right hold a sample pair
//   o_sample_ready   holding buffer empty; a pair is accepted on valid&&ready
//   i_left, i_right  two's complement samples
//   o_bclk           codec bit clock, 50% duty
//   o_daclrc         frame sync, high during the first BCLK period of a frame
//   o_dacdat         serial data, MSB first, changes on falling BCLK
//   o_frame_start    one-cycle pulse at every frame load
//   o_underflow_count  (only with AUDIO_DAC_UNDERFLOW_CNT_EN) saturating
//                      count of frames loaded with an empty buffer
//
// Optional feature macro: AUDIO_DAC_UNDERFLOW_CNT_EN
// ---------------------------------------------------------------------------
module audio_dac_serializer #(
  parameter int BCLK_DIV    = 4,
  parameter int FRAME_BCLKS = 64
) (
  input  logic        i_clk,
  input  logic        i_nrst,
  input  logic        i_init_ready,
  input  logic        i_sample_valid,
  output logic        o_sample_ready,
  input  logic [15:0] i_left,
  input  logic [15:0] i_right,
  output logic        o_bclk,
  output logic        o_daclrc,
  output logic        o_dacdat,
  output logic        o_frame_start
`ifdef AUDIO_DAC_UNDERFLOW_CNT_EN
  ,
  output logic [15:0] o_underflow_count
`endif
);

  localparam int DIV_W = $clog2(BCLK_DIV);
  localparam int CNT_W = $clog2(FRAME_BCLKS);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t           r_state;
  logic [DIV_W-1:0] r_div_cnt;
  logic [CNT_W-1:0] r_bit_cnt;
  logic             r_bclk;
  logic             r_daclrc;
  logic             r_dacdat;
  logic             r_frame_start;
  logic             r_buf_full;
  logic [31:0]      r_buf;
  logic [31:0]      r_shift;

  logic        w_entry;
  logic        w_run;
  logic        w_div_wrap;
  logic        w_bclk_fall;
  logic        w_last_bit;
  logic        w_load;
  logic        w_accept;
  logic [31:0] w_load_word;

  assign w_entry     = (r_state == S_IDLE) && i_init_ready;
  assign w_run       = (r_state == S_RUN) && i_init_ready;
  assign w_div_wrap  = (r_div_cnt == DIV_W'(BCLK_DIV - 1));
  assign w_bclk_fall = w_run && w_div_wrap && r_bclk;
  assign w_last_bit  = (r_bit_cnt == CNT_W'(FRAME_BCLKS - 1));
  // RUN entry doubles as the first frame load, so bit 0 appears right away.
  assign w_load      = w_entry || (w_bclk_fall && w_last_bit);
  assign w_accept    = w_run && !r_buf_full && i_sample_valid;
  // An empty buffer at load time mutes the frame.
  assign w_load_word = r_buf_full ? r_buf : 32'h0;

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_state       <= S_IDLE;
      r_div_cnt     <= '0;
      r_bit_cnt     <= '0;
      r_bclk        <= 1'b0;
      r_daclrc      <= 1'b0;
      r_dacdat      <= 1'b0;
      r_frame_start <= 1'b0;
      r_buf_full    <= 1'b0;
      r_buf         <= '0;
      r_shift       <= '0;
    end else if (!i_init_ready) begin
      // Dropping init aborts the frame and discards any pending pair.
      r_state       <= S_IDLE;
      r_div_cnt     <= '0;
      r_bit_cnt     <= '0;
      r_bclk        <= 1'b0;
      r_daclrc      <= 1'b0;
      r_dacdat      <= 1'b0;
      r_frame_start <= 1'b0;
      r_buf_full    <= 1'b0;
      r_shift       <= '0;
    end else begin
      r_state       <= S_RUN;
      r_frame_start <= w_load;

      // BCLK divider and bit counter
      if (w_entry) begin
        r_div_cnt <= '0;
        r_bclk    <= 1'b0;
        r_bit_cnt <= '0;
      end else begin
        r_div_cnt <= w_div_wrap ? '0 : r_div_cnt + DIV_W'(1);
        if (w_div_wrap) begin
          r_bclk <= ~r_bclk;
        end
        if (w_bclk_fall) begin
          r_bit_cnt <= w_last_bit ? '0 : r_bit_cnt + CNT_W'(1);
        end
      end

      // Holding buffer, shift register and serial outputs
      if (w_load) begin
        r_shift    <= w_load_word;
        r_dacdat   <= w_load_word[31];
        r_daclrc   <= 1'b1;
        // A pair accepted in the load cycle lands in the just-emptied buffer.
        r_buf_full <= w_accept;
        if (w_accept) begin
          r_buf <= {i_left, i_right};
        end
      end else begin
        if (w_accept) begin
          r_buf_full <= 1'b1;
          r_buf      <= {i_left, i_right};
        end
        if (w_bclk_fall) begin
          // Zeros shift in, so bits past the stereo pair are driven low.
          r_shift  <= {r_shift[30:0], 1'b0};
          r_dacdat <= r_shift[30];
          r_daclrc <= 1'b0;
        end
      end
    end
  end

  assign o_bclk         = r_bclk;
  assign o_daclrc       = r_daclrc;
  assign o_dacdat       = r_dacdat;
  assign o_frame_start  = r_frame_start;
  assign o_sample_ready = (r_state == S_RUN) && !r_buf_full;

`ifdef AUDIO_DAC_UNDERFLOW_CNT_EN
  logic [15:0] r_underflow_cnt;

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_underflow_cnt <= '0;
    end else if (i_init_ready && w_load && !r_buf_full &&
                 (r_underflow_cnt != 16'hFFFF)) begin
      r_underflow_cnt <= r_underflow_cnt + 16'd1;
    end
  end

  assign o_underflow_count = r_underflow_cnt;
`endif

endmodule

// File: doc/audio_dac_serializer.md
AUDIO_DAC_SERIALIZER -- requirements
Module: mod_audio_dac_serializer

Interface
REQ-001 SHALL have parameter BCLK_DIV, default 4: i_clk cycles per BCLK half-period (legal range 2..255).
REQ-002 SHALL have parameter FRAME_BCLKS, default 64: BCLK periods per frame (legal range 33..256).
REQ-003 SHALL have port i_clk, input, 1 bit: global clock, single clock domain.
REQ-004 SHALL have port i_nrst, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port i_init_ready, input, 1 bit: codec configured; serializer runs only while it is high.
REQ-006 SHALL have port i_sample_valid, input, 1 bit: i_left/i_right hold a sample pair.
REQ-007 SHALL have port o_sample_ready, output, 1 bit: holding buffer empty; the block accepts a pair.
REQ-008 SHALL have port i_left, input, 16 bits: left sample, two's complement.
REQ-009 SHALL have port i_right, input, 16 bits: right sample, two's complement.
REQ-010 SHALL have port o_bclk, output, 1 bit: codec bit clock (the codec is slave).
REQ-011 SHALL have port o_daclrc, output, 1 bit: DSP frame sync.
REQ-012 SHALL have port o_dacdat, output, 1 bit: serial DAC data, MSB first.
REQ-013 SHALL have port o_frame_start, output, 1 bit: one-i_clk pulse at each frame load.

Function
REQ-014 SHALL implement states IDLE and RUN; IDLE->RUN when i_init_ready=1; any state->IDLE the cycle after i_init_ready=0 is sampled.
REQ-015 SHALL, in IDLE, hold o_bclk=0, o_daclrc=0, o_dacdat=0 and o_sample_ready=0, and empty the holding buffer.
REQ-016 SHALL provide a one-entry holding buffer; in RUN, o_sample_ready=1 exactly when the buffer is empty; a pair is accepted when i_sample_valid&&o_sample_ready is high at a rising i_clk edge.
REQ-017 SHALL generate o_bclk from a divider that toggles every BCLK_DIV i_clk cycles, giving 50% duty; o_bclk=0 on RUN entry.
REQ-018 SHALL update o_daclrc and o_dacdat only on o_bclk falling transitions and on RUN entry, so the codec samples on rising BCLK.
REQ-019 SHALL keep bit counter bit_cnt 0..FRAME_BCLKS-1, incremented per BCLK period and wrapping to 0.
REQ-020 SHALL, at bit_cnt=0 (frame load), move the buffer into a 32-bit shift register {left,right}, empty the buffer and pulse o_frame_start for one cycle.
REQ-021 SHALL implement DSP mode B: o_daclrc=1 only during bit_cnt=0, with left[15] on o_dacdat in that same period.
REQ-022 SHALL drive left[15..0] during bit_cnt 0..15, right[15..0] during 16..31, and 0 during 32..FRAME_BCLKS-1.
REQ-023 SHALL, on underflow (buffer empty at frame load), load 32'h0 (mute) and keep the frame timing unchanged.
REQ-024 SHALL, when accept and frame load coincide, load the old buffer content and store the new pair, so no sample is lost.
REQ-025 SHALL drive bit 0 of the first frame in the cycle after RUN entry; the first o_bclk rise follows BCLK_DIV cycles later.

Reset
REQ-026 SHALL, while i_nrst=0, force the state to IDLE, all outputs to 0, all counters to 0, the buffer to empty and the shift register to 0.
REQ-027 SHALL begin at IDLE on the first edge after reset release, even if i_init_ready is already high.

Configuration
REQ-028 SHALL, when macro AUDIO_DAC_UNDERFLOW_CNT_EN is defined, add output o_underflow_count (16 bits), reset to 0, incremented on each underflow frame and saturating at 16'hFFFF.
REQ-029 SHALL, without AUDIO_DAC_UNDERFLOW_CNT_EN, omit o_underflow_count and its counter; all other behaviour is identical.

Verification
REQ-030 SHALL cover this case: BCLK_DIV=2, FRAME_BCLKS=64, pair L=16'hA5F0, R=16'h0F3C pre-loaded -> o_daclrc high for 4 i_clk cycles, bits on rising BCLK read A5F0 then 0F3C then 32 zeros, and the frame period is 256 i_clk cycles.
REQ-031 SHALL cover this case: i_sample_valid=0 for 3 frames -> o_dacdat=0 throughout, o_frame_start pulses 3 times, and o_underflow_count=3 (macro on).
REQ-032 SHALL cover this case: a valid pair presented in the exact frame-load cycle with the buffer full -> the old pair is serialized now and the new pair is serialized in the next frame.
REQ-033 SHALL cover this case: i_init_ready dropped at bit_cnt=20 -> the next cycle shows o_bclk=0, o_daclrc=0, o_dacdat=0 and o_sample_ready=0; on i_init_ready re-rise the block restarts at bit_cnt=0.
REQ-034 SHALL cover this case: i_nrst pulsed low mid-frame asynchronously -> all outputs go to 0 immediately, without waiting for a clock edge.
REQ-035 SHALL cover this case: underflow counter driven to 16'hFFFF, then one more underflow -> the count stays at 16'hFFFF.
